forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
//  Control-side counterpart of the 32-bit 3:1 ALU operand muxes: generates their 2-bit selects.
//  Tracks destination-register metadata through EX/MEM/WB in shadow registers and compares it to the EX operands.
//  Also detects load-use hazards and issues a stall plus bubble; sits beside the ID/EX pipeline registers.
//  Select code matches the mux: 2'b00 = register file, 2'b01 = MEM/WB result, 2'b1x = EX/MEM result (unit drives 2'b10).
// PARAMETERS
//  REG_AW    5    register-address width
//  ZERO_REG  0    hard-wired zero register; never forwarded, never causes a stall
// PORTS
//  clk           in   1       pipeline clock; all state on rising edge
//  reset         in   1       asynchronous, active-high; clears all state
//  id_valid      in   1       ID holds a real instruction
//  id_rs         in   REG_AW  source A of the ID instruction
//  id_rt         in   REG_AW  source B of the ID instruction
//  id_uses_rt    in   1       id_rt is a true source (0 for I-type loads/ALU-imm)
//  id_dest       in   REG_AW  destination after RegDst resolution
//  id_regwrite   in   1       ID instruction writes the register file
//  id_memread    in   1       ID instruction is a load
//  flush         in   1       taken branch/jump: squash the ID instruction
//  fwd_a         out  2       select for the ALU operand A mux (EX stage)
//  fwd_b         out  2       select for the ALU operand B mux (EX stage)
//  stall         out  1       hold PC and IF/ID; the unit inserts the bubble itself
//  id_byp_a      out  1       WB-to-ID register-file bypass for rs (see CONFIGURATION)
//  id_byp_b      out  1       WB-to-ID register-file bypass for rt
// BEHAVIOUR
//  - State: EX{rs,rt,dest,rw,mr}, MEM{dest,rw}, WB{dest,rw}. Reset clears all fields to 0, so outputs reset to fwd=00, stall=0, byp=0.
//  - Every edge: WB<=MEM, MEM<=EX{dest,rw}. EX loads the ID fields; a bubble (EX rw=0, mr=0, regs=0) loads instead when stall|flush|!id_valid.
//  - stall (combinational) = EX.mr & EX.dest!=ZERO_REG & (EX.dest==id_rs | (id_uses_rt & EX.dest==id_rt)) & id_valid.
//  - A stall lasts exactly 1 cycle: after the bubble, EX.mr=0 and the load sits in MEM, where the MEM/WB path covers it next cycle.
//  - fwd_a: 2'b10 if MEM.rw & MEM.dest!=0 & MEM.dest==EX.rs; else 2'b01 if WB.rw & WB.dest!=0 & WB.dest==EX.rs; else 2'b00.
//    fwd_b is identical using EX.rt. When both MEM and WB match, MEM wins (youngest producer).
//  - Selects are combinational from registered state: zero added latency and valid in the same cycle the instruction is in EX.
//  - flush and stall together: flush wins and EX gets a bubble; stall is still driven to the PC/IF logic.
//  - Async reset mid-stall: stall deasserts immediately and all in-flight metadata is lost (bubbles).
// CONFIGURATION
//  WB_ID_BYPASS_EN defined: id_byp_a = WB.rw & WB.dest!=0 & WB.dest==id_rs; id_byp_b likewise for id_rt, gated by id_uses_rt.
//    This supports a register file without write-before-read.
//  WB_ID_BYPASS_EN undefined: id_byp_a/id_byp_b are tied to 0 and no comparators are generated.
// STRUCTURE
//  Shared package/header: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and REG_AW.
//  One sub-module, fwd_select: a combinational comparator for one operand that returns a 2-bit select.
//    Instantiate it twice, for A and B.
//  Stage shadow registers and stall logic live in the top module.
// TESTING
//  1. add $3,$1,$2 ; sub $4,$3,$5 back-to-back -> sub in EX: fwd_a=10, fwd_b=00, stall=0.
//  2. add $3 ; nop ; or $6,$7,$3 -> or in EX: fwd_b=01, fwd_a=00.
//  3. add $3 ; add $3 ; and $8,$3,$3 -> fwd_a=fwd_b=10 (MEM has priority over WB).
//  4. lw $9,0($1) ; add $10,$9,$2 -> stall=1 for exactly 1 cycle, bubble in EX; next cycle the add is in EX with fwd_a=01.
//  5. Writes to $0 in every position and lw $0 followed by a use -> fwd stays 00, stall=0.
//  6. Assert reset mid-stall -> stall, fwd_a and fwd_b read 0 before the next edge.
//     With flush=1 during a load-use stall, EX gets a bubble and no forward is seen 2 cycles later.

Source files
------------

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: ALU operand mux select codes
// and the default register-address width.
package forwarding_hazard_unit_pkg;

  localparam int unsigned REG_AW = 5;

  // Encodings must match the 3:1 operand mux; 2'b11 also selects EX/MEM there.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer of src.
module fwd_select #(
  parameter int unsigned REG_AW   = forwarding_hazard_unit_pkg::REG_AW,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_rw,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_rw,
  output logic [1:0]        sel
);
  import forwarding_hazard_unit_pkg::*;

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(ZERO_REG);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_rw && (mem_dest != ZERO) && (mem_dest == src);
  assign wb_hit  = wb_rw  && (wb_dest  != ZERO) && (wb_dest  == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding select and load-use stall generation for the EX stage.
// Optional WB-to-ID register-file bypass enabled by defining WB_ID_BYPASS_EN.
module forwarding_hazard_unit #(
  parameter int unsigned REG_AW   = forwarding_hazard_unit_pkg::REG_AW,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              id_byp_a,
  output logic              id_byp_b
);
  import forwarding_hazard_unit_pkg::*;

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(ZERO_REG);

  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic              ex_rw, ex_mr, mem_rw, wb_rw;
  logic              bubble;

  assign stall = ex_mr && (ex_dest != ZERO) && id_valid &&
                 ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

  // Stall also forces a bubble, so the held ID instruction re-enters EX one cycle later.
  assign bubble = stall || flush || !id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_dest  <= '0;
      ex_rw    <= 1'b0;
      ex_mr    <= 1'b0;
      mem_dest <= '0;
      mem_rw   <= 1'b0;
      wb_dest  <= '0;
      wb_rw    <= 1'b0;
    end else begin
      wb_dest  <= mem_dest;
      wb_rw    <= mem_rw;
      mem_dest <= ex_dest;
      mem_rw   <= ex_rw;
      if (bubble) begin
        ex_rs   <= '0;
        ex_rt   <= '0;
        ex_dest <= '0;
        ex_rw   <= 1'b0;
        ex_mr   <= 1'b0;
      end else begin
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
        ex_dest <= id_dest;
        ex_rw   <= id_regwrite;
        ex_mr   <= id_memread;
      end
    end
  end

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src      (ex_rs),
    .mem_dest (mem_dest),
    .mem_rw   (mem_rw),
    .wb_dest  (wb_dest),
    .wb_rw    (wb_rw),
    .sel      (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src      (ex_rt),
    .mem_dest (mem_dest),
    .mem_rw   (mem_rw),
    .wb_dest  (wb_dest),
    .wb_rw    (wb_rw),
    .sel      (fwd_b)
  );

`ifdef WB_ID_BYPASS_EN
  assign id_byp_a = wb_rw && (wb_dest != ZERO) && (wb_dest == id_rs);
  assign id_byp_b = wb_rw && (wb_dest != ZERO) && (wb_dest == id_rt) && id_uses_rt;
`else
  assign id_byp_a = 1'b0;
  assign id_byp_b = 1'b0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: directed pipeline scenarios plus random traffic
// compared against a history-queue model; honours WB_ID_BYPASS_EN when defined.
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_uses_rt = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, id_byp_a, id_byp_b;

  int vectors = 0;
  int miscompares = 0;

  logic       lit_en = 1'b0;
  logic [1:0] lit_a = '0, lit_b = '0;
  logic       lit_s = 1'b0;
  logic       rchk = 1'b0;

  forwarding_hazard_unit #(.REG_AW(5), .ZERO_REG(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .id_byp_a    (id_byp_a),
    .id_byp_b    (id_byp_b)
  );

  always #5 clk = ~clk;

  // Model: list of instructions that entered EX, youngest first ([0]=EX, [1]=MEM, [2]=WB).
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } ent_t;

  localparam ent_t BUB = '0;
  ent_t hist[$] = '{BUB, BUB, BUB};

  function automatic logic m_stall();
    ent_t e = hist[0];
    return id_valid && e.mr && (e.dest != 0) &&
           ((e.dest == id_rs) || (id_uses_rt && (e.dest == id_rt)));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    for (int k = 1; k <= 2; k++)
      if (hist[k].rw && (hist[k].dest != 0) && (hist[k].dest == src))
        return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_byp(input logic [4:0] src, input logic en);
`ifdef WB_ID_BYPASS_EN
    return en && hist[2].rw && (hist[2].dest != 0) && (hist[2].dest == src);
`else
    return 1'b0 && en && (src == 5'd31);
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist = '{BUB, BUB, BUB};
    end else begin
      ent_t n;
      if (m_stall() || flush || !id_valid) n = BUB;
      else n = '{rs: id_rs, rt: id_rt, dest: id_dest, rw: id_regwrite, mr: id_memread};
      hist.push_front(n);
      hist.pop_back();
    end
  end

  task automatic cmp(input string name, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  always @(negedge clk or posedge rchk) begin
    cmp("fwd_a", fwd_a, m_fwd(hist[0].rs));
    cmp("fwd_b", fwd_b, m_fwd(hist[0].rt));
    cmp("stall", {1'b0, stall}, {1'b0, m_stall()});
    cmp("id_byp_a", {1'b0, id_byp_a}, {1'b0, m_byp(id_rs, 1'b1)});
    cmp("id_byp_b", {1'b0, id_byp_b}, {1'b0, m_byp(id_rt, id_uses_rt)});
    if (lit_en) begin
      cmp("lit_fwd_a", fwd_a, lit_a);
      cmp("lit_fwd_b", fwd_b, lit_b);
      cmp("lit_stall", {1'b0, stall}, {1'b0, lit_s});
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic [4:0] d, input logic rw,
                        input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    id_dest = d; id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  // Present one ID instruction for a cycle; literals describe the instruction now in EX.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [4:0] d, input logic rw,
                      input logic mr, input logic fl, input logic le,
                      input logic [1:0] ea, input logic [1:0] eb, input logic es);
    set_id(v, rs, rt, ut, d, rw, mr, fl);
    lit_en = le; lit_a = ea; lit_b = eb; lit_s = es;
    @(posedge clk); #1;
    lit_en = 1'b0;
  endtask

  task automatic nop(input logic le, input logic [1:0] ea, input logic [1:0] eb);
    step(0, 0, 0, 0, 0, 0, 0, 0, le, ea, eb, 1'b0);
  endtask

  initial begin
    lit_en = 1'b1;
    @(negedge clk);
    #1 lit_en = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    nop(0, 2'b00, 2'b00);

    // add $3,$1,$2 ; sub $4,$3,$5
    step(1, 1, 2, 1, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    step(1, 3, 5, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(1, 2'b10, 2'b00);

    // add $3 ; nop ; or $6,$7,$3
    step(1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(0, 2'b00, 2'b00);
    step(1, 7, 3, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(1, 2'b00, 2'b01);

    // add $3 ; add $3 ; and $8,$3,$3
    step(1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    step(1, 4, 5, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    step(1, 3, 3, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(1, 2'b10, 2'b10);

    // lw $9,0($1) ; add $10,$9,$2 : one stall, then WB forward
    step(1, 1, 9, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    step(1, 9, 2, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, 1);
    step(1, 9, 2, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    nop(1, 2'b01, 2'b00);

    // $0 as destination never forwards or stalls
    step(1, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    step(1, 0, 0, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    nop(1, 2'b00, 2'b00);
    step(1, 1, 2, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    step(1, 1, 2, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    step(1, 0, 0, 1, 11, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(1, 2'b00, 2'b00);

    // reset asserted while a stall (and a forward) is active
    step(1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    step(1, 3, 9, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    set_id(1, 9, 2, 1, 10, 1, 0, 0);
    lit_en = 1'b1; lit_a = 2'b10; lit_b = 2'b00; lit_s = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    lit_a = 2'b00; lit_b = 2'b00; lit_s = 1'b0;
    #1 rchk = 1'b1;
    #1 rchk = 1'b0;
    lit_en = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    nop(1, 2'b00, 2'b00);

    // flush during a load-use stall: stall still driven, EX gets a bubble
    step(1, 1, 9, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    step(1, 9, 2, 1, 10, 1, 0, 1, 1, 2'b00, 2'b00, 1);
    nop(1, 2'b00, 2'b00);
    nop(1, 2'b00, 2'b00);

    // random traffic over a small register window to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      logic mr;
      mr = ($urandom_range(3) == 0);
      set_id($urandom_range(3) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
             1'($urandom_range(1)), 5'($urandom_range(7)),
             mr || ($urandom_range(2) != 0), mr, $urandom_range(7) == 0);
      if (i == 1500) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
      @(posedge clk); #1;
    end

    nop(0, 2'b00, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
